// File: rtl/alu_pkg.sv
// Shared constants and types for the UART packet sequencer and its ALU link.
package alu_pkg;

  localparam logic [7:0]  OPC_ECHO = 8'hEC;
  localparam logic [7:0]  OPC_ADD  = 8'hA0;
  localparam logic [7:0]  OPC_MUL  = 8'hA1;
  localparam logic [7:0]  OPC_DIV  = 8'hA2;
  localparam logic [7:0]  ERR_BYTE = 8'hEE;
  localparam logic [15:0] HDR_LEN  = 16'd4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_MUL = 2'd1,
    ALU_DIV = 2'd2
  } alu_op_e;

  typedef enum logic [3:0] {
    HDR0,
    HDR1,
    HDR2,
    HDR3,
    ECHO,
    OPND,
    ALU_REQ,
    ALU_WAIT,
    RESP,
    DRAIN,
    ERR
  } state_e;

  // One request to the ALU core: operation plus accumulator and new operand.
  typedef struct packed {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

  function automatic logic is_arith(input logic [7:0] opc);
    return (opc == OPC_ADD) || (opc == OPC_MUL) || (opc == OPC_DIV);
  endfunction

  function automatic alu_op_e opcode_to_op(input logic [7:0] opc);
    case (opc)
      OPC_MUL: return ALU_MUL;
      OPC_DIV: return ALU_DIV;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_packet_ctrl_if.sv
// Byte-stream (RX/TX) and ALU request/result bundle of the packet sequencer.
interface alu_packet_ctrl_if #(
  parameter int unsigned datawidth_p  = 8,
  parameter int unsigned opnd_bytes_p = 4
);
  localparam int unsigned WordW = datawidth_p * opnd_bytes_p;

  logic [datawidth_p-1:0] rx_data_i;
  logic                   rx_valid_i;
  logic                   rx_ready_o;

  logic [datawidth_p-1:0] tx_data_o;
  logic                   tx_valid_o;
  logic                   tx_ready_i;

  logic [1:0]             alu_op_o;
  logic [WordW-1:0]       alu_a_o;
  logic [WordW-1:0]       alu_b_o;
  logic                   alu_valid_o;
  logic                   alu_ready_i;
  logic [WordW-1:0]       alu_result_i;
  logic                   alu_result_valid_i;

  // Controller side.
  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i,
    input  alu_ready_i, alu_result_i, alu_result_valid_i,
    output rx_ready_o, tx_data_o, tx_valid_o,
    output alu_op_o, alu_a_o, alu_b_o, alu_valid_o
  );

  // UART / ALU side.
  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i,
    output alu_ready_i, alu_result_i, alu_result_valid_i,
    input  rx_ready_o, tx_data_o, tx_valid_o,
    input  alu_op_o, alu_a_o, alu_b_o, alu_valid_o
  );
endinterface

// File: rtl/byte_word_shift.sv
// Little-endian word assembler/serialiser: bytes shift in at the top, out at the bottom.
module byte_word_shift #(
  parameter int unsigned byte_w_p = 8,
  parameter int unsigned nbytes_p = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         load_i,
  input  logic                         shift_in_i,
  input  logic                         shift_out_i,
  input  logic [byte_w_p-1:0]          byte_i,
  input  logic [byte_w_p*nbytes_p-1:0] word_i,
  output logic [byte_w_p*nbytes_p-1:0] word_o,
  output logic [$clog2(nbytes_p)-1:0]  cnt_o
);
  localparam int unsigned WordW = byte_w_p * nbytes_p;
  localparam int unsigned CntW  = $clog2(nbytes_p);

  logic [WordW-1:0] word_q, word_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      word_d = word_i;
      cnt_d  = '0;
    end else if (clr_i) begin
      cnt_d  = '0;
    end else if (shift_in_i) begin
      word_d = {byte_i, word_q[WordW-1:byte_w_p]};
      cnt_d  = CntW'(cnt_q + 1'b1);
    end else if (shift_out_i) begin
      word_d = {byte_w_p'(0), word_q[WordW-1:byte_w_p]};
      cnt_d  = CntW'(cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = word_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/alu_packet_ctrl.sv
// Packet sequencer: parses framed RX commands, echoes payloads, drives the ALU
// with a running accumulator and serialises the 32-bit result to TX.
module alu_packet_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned datawidth_p  = 8,
  parameter int unsigned opnd_bytes_p = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_packet_ctrl_if.master bus
);
  localparam int unsigned WordW = datawidth_p * opnd_bytes_p;
  localparam int unsigned CntW  = $clog2(opnd_bytes_p);

  state_e                 state_q;
  logic [datawidth_p-1:0] opcode_q;
  logic [datawidth_p-1:0] len_lo_q;
  logic [15:0]            rem_q;
  logic                   first_q;
  logic [WordW-1:0]       acc_q;
  logic [datawidth_p-1:0] tx_data_q;
  logic                   tx_valid_q;
  alu_req_t               req_q;
  logic                   alu_valid_q;

  logic                   rx_ready_c;
  logic                   rx_fire_c;
  logic                   tx_fire_c;
  logic [15:0]            len_c;
  logic [15:0]            rem_hdr_c;
  logic [WordW-1:0]       opnd_c;
  logic                   resp_start_c;
  logic [WordW-1:0]       resp_word_c;
  logic                   sh_clr_c;
  logic                   sh_in_c;
  logic                   sh_out_c;
  logic                   sh_last_c;
  logic [WordW-1:0]       sh_word;
  logic [CntW-1:0]        sh_cnt;

  assign rx_fire_c = bus.rx_valid_i && rx_ready_c;
  assign tx_fire_c = tx_valid_q && bus.tx_ready_i;
  assign len_c     = {bus.rx_data_i, len_lo_q};
  assign rem_hdr_c = 16'(len_c - HDR_LEN);
  assign opnd_c    = {bus.rx_data_i, sh_word[WordW-1:datawidth_p]};
  assign sh_last_c = (sh_cnt == CntW'(opnd_bytes_p - 1));

  // RX acceptance; ECHO and DRAIN stop at the packet boundary so the next header waits.
  always_comb begin
    rx_ready_c = 1'b0;
    if (!rst_i) begin
      case (state_q)
        HDR0, HDR1, HDR2, HDR3, OPND: rx_ready_c = 1'b1;
        ECHO:    rx_ready_c = (rem_q != 16'd0) && (!tx_valid_q || bus.tx_ready_i);
        DRAIN:   rx_ready_c = (rem_q != 16'd0);
        default: rx_ready_c = 1'b0;
      endcase
    end
  end

  // Shared shifter: assembles operands in OPND, serialises the result in RESP.
  always_comb begin
    resp_start_c = 1'b0;
    resp_word_c  = '0;
    sh_clr_c     = 1'b0;
    sh_in_c      = 1'b0;
    sh_out_c     = 1'b0;
    case (state_q)
      HDR3: sh_clr_c = rx_fire_c;
      OPND: begin
        if (rx_fire_c) begin
          if (sh_last_c && first_q && (rem_q == 16'd1)) begin
            resp_start_c = 1'b1;
            resp_word_c  = opnd_c;
          end else begin
            sh_in_c = 1'b1;
          end
        end
      end
      ALU_WAIT: begin
        if (bus.alu_result_valid_i && (rem_q == 16'd0)) begin
          resp_start_c = 1'b1;
          resp_word_c  = bus.alu_result_i;
        end
      end
      RESP:    sh_out_c = tx_fire_c && !sh_last_c;
      default: ;
    endcase
  end

  byte_word_shift #(
    .byte_w_p (datawidth_p),
    .nbytes_p (opnd_bytes_p)
  ) u_shift (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (sh_clr_c),
    .load_i      (resp_start_c),
    .shift_in_i  (sh_in_c),
    .shift_out_i (sh_out_c),
    .byte_i      (bus.rx_data_i),
    .word_i      (WordW'(resp_word_c >> datawidth_p)),
    .word_o      (sh_word),
    .cnt_o       (sh_cnt)
  );

  // Sequencer FSM with registered TX and ALU outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= HDR0;
      opcode_q    <= '0;
      len_lo_q    <= '0;
      rem_q       <= '0;
      first_q     <= 1'b0;
      acc_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      req_q       <= '{op: ALU_ADD, a: '0, b: '0};
      alu_valid_q <= 1'b0;
    end else begin
      case (state_q)
        HDR0: begin
          if (rx_fire_c) begin
            opcode_q <= bus.rx_data_i;
            state_q  <= HDR1;
          end
        end
        HDR1: begin
          if (rx_fire_c) state_q <= HDR2;
        end
        HDR2: begin
          if (rx_fire_c) begin
            len_lo_q <= bus.rx_data_i;
            state_q  <= HDR3;
          end
        end
        HDR3: begin
          if (rx_fire_c) begin
            rem_q   <= rem_hdr_c;
            first_q <= 1'b1;
            if (len_c < HDR_LEN) begin
              state_q    <= ERR;
              tx_data_q  <= ERR_BYTE;
              tx_valid_q <= 1'b1;
            end else if (opcode_q == OPC_ECHO) begin
              state_q <= (rem_hdr_c == 16'd0) ? HDR0 : ECHO;
            end else if (!is_arith(opcode_q) || (rem_hdr_c == 16'd0) ||
                         (rem_hdr_c[CntW-1:0] != '0)) begin
              state_q <= DRAIN;
            end else begin
              state_q <= OPND;
            end
          end
        end
        ECHO: begin
          if (rx_fire_c) begin
            tx_data_q  <= bus.rx_data_i;
            tx_valid_q <= 1'b1;
            rem_q      <= 16'(rem_q - 16'd1);
          end else if (tx_fire_c) begin
            tx_valid_q <= 1'b0;
            if (rem_q == 16'd0) state_q <= HDR0;
          end
        end
        OPND: begin
          if (rx_fire_c) begin
            rem_q <= 16'(rem_q - 16'd1);
            if (sh_last_c) begin
              if (first_q) begin
                acc_q   <= opnd_c;
                first_q <= 1'b0;
              end else begin
                req_q       <= '{op: opcode_to_op(opcode_q), a: acc_q, b: opnd_c};
                alu_valid_q <= 1'b1;
                state_q     <= ALU_REQ;
              end
            end
            if (resp_start_c) begin
              tx_data_q  <= resp_word_c[datawidth_p-1:0];
              tx_valid_q <= 1'b1;
              state_q    <= RESP;
            end
          end
        end
        ALU_REQ: begin
          if (bus.alu_ready_i) begin
            alu_valid_q <= 1'b0;
            state_q     <= ALU_WAIT;
          end
        end
        ALU_WAIT: begin
          if (bus.alu_result_valid_i) begin
            acc_q   <= bus.alu_result_i;
            state_q <= OPND;
            if (resp_start_c) begin
              tx_data_q  <= resp_word_c[datawidth_p-1:0];
              tx_valid_q <= 1'b1;
              state_q    <= RESP;
            end
          end
        end
        RESP: begin
          if (tx_fire_c) begin
            if (sh_last_c) begin
              tx_valid_q <= 1'b0;
              state_q    <= HDR0;
            end else begin
              tx_data_q <= sh_word[datawidth_p-1:0];
            end
          end
        end
        DRAIN: begin
          if (rem_q == 16'd0) begin
            tx_data_q  <= ERR_BYTE;
            tx_valid_q <= 1'b1;
            state_q    <= ERR;
          end else if (rx_fire_c) begin
            rem_q <= 16'(rem_q - 16'd1);
          end
        end
        ERR: begin
          if (tx_fire_c) begin
            tx_valid_q <= 1'b0;
            state_q    <= HDR0;
          end
        end
        default: state_q <= HDR0;
      endcase
    end
  end

  assign bus.rx_ready_o  = rx_ready_c;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.tx_valid_o  = tx_valid_q;
  assign bus.alu_op_o    = req_q.op;
  assign bus.alu_a_o     = req_q.a;
  assign bus.alu_b_o     = req_q.b;
  assign bus.alu_valid_o = alu_valid_q;

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// Scoreboard bench for alu_packet_ctrl: directed packets, expected TX bytes and
// ALU requests queued at issue time and checked by an independent monitor.
module tb_alu_packet_ctrl;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_packet_ctrl_if #(.datawidth_p(8), .opnd_bytes_p(4)) bus ();

  alu_packet_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;
  int tx_mode = 0;    // 0: ready high, 1: toggling, 2: held low
  int alu_delay = 0;

  logic [7:0]  exp_tx[$];
  exp_req_t    exp_alu[$];
  logic [31:0] alu_res_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic note_fail(input string name, input logic [31:0] act);
    checks++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  task automatic expect_tx(input byte_q_t b);
    foreach (b[i]) exp_tx.push_back(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.rx_ready_o) break;
      n++;
      if (n > 200) begin
        note_fail("rx_accept_timeout", 32'(b));
        break;
      end
    end
    @(posedge clk); #1;
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input byte_q_t b);
    foreach (b[i]) send_byte(b[i]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_alu.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending"}, 32'(exp_tx.size() + exp_alu.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_tx.delete();
    exp_alu.delete();
    alu_res_q.delete();
  endtask

  // TX sink: ready pattern chosen by the running test.
  initial begin : tx_sink
    bus.tx_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (tx_mode)
        0:       bus.tx_ready_i = 1'b1;
        1:       bus.tx_ready_i = ~bus.tx_ready_i;
        default: bus.tx_ready_i = 1'b0;
      endcase
    end
  end

  // ALU stand-in: delayed ready, then one result pulse from the hand-computed list.
  initial begin : alu_env
    bus.alu_ready_i        = 1'b0;
    bus.alu_result_valid_i = 1'b0;
    bus.alu_result_i       = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.alu_valid_o && !rst) begin
        repeat (alu_delay) begin
          @(posedge clk); #1;
        end
        bus.alu_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.alu_ready_i = 1'b0;
        @(posedge clk); #1;
        if (alu_res_q.size() != 0) begin
          bus.alu_result_i       = alu_res_q.pop_front();
          bus.alu_result_valid_i = 1'b1;
          @(posedge clk); #1;
          bus.alu_result_valid_i = 1'b0;
        end
      end
    end
  end

  // Monitor: every presented TX byte / ALU request is compared with the queue head.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.tx_valid_o) begin
          if (exp_tx.size() == 0) note_fail("tx_unexpected", 32'(bus.tx_data_o));
          else begin
            chk("tx_data", 32'(bus.tx_data_o), 32'(exp_tx[0]));
            if (bus.tx_ready_i) void'(exp_tx.pop_front());
          end
        end
        if (bus.alu_valid_o) begin
          if (exp_alu.size() == 0) note_fail("alu_unexpected", bus.alu_b_o);
          else begin
            chk("alu_op", 32'(bus.alu_op_o), 32'(exp_alu[0].op));
            chk("alu_a", bus.alu_a_o, exp_alu[0].a);
            chk("alu_b", bus.alu_b_o, exp_alu[0].b);
            if (bus.alu_ready_i) void'(exp_alu.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = '0;

    // Reset state.
    @(negedge clk);
    chk("rst_rx_ready", 32'(bus.rx_ready_o), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid_o), 32'd0);
    chk("rst_alu_valid", 32'(bus.alu_valid_o), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data_o), 32'd0);
    chk("rst_alu_a", bus.alu_a_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rx_ready", 32'(bus.rx_ready_o), 32'd1);
    @(posedge clk); #1;

    // ECHO.
    expect_tx('{8'h41, 8'h42, 8'h43});
    send_pkt('{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43});
    wait_idle("echo");

    // ADD: 5 + 0xFFFFFFFF wraps to 4.
    exp_alu.push_back('{op: 2'd0, a: 32'd5, b: 32'hFFFF_FFFF});
    alu_res_q.push_back(32'd4);
    expect_tx('{8'h04, 8'h00, 8'h00, 8'h00});
    send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
               8'hFF, 8'hFF, 8'hFF, 8'hFF});
    wait_idle("add");

    // MUL 3*4*5 with ALU and TX backpressure.
    alu_delay = 3;
    tx_mode   = 1;
    exp_alu.push_back('{op: 2'd1, a: 32'd3, b: 32'd4});
    exp_alu.push_back('{op: 2'd1, a: 32'd12, b: 32'd5});
    alu_res_q.push_back(32'd12);
    alu_res_q.push_back(32'd60);
    expect_tx('{8'h3C, 8'h00, 8'h00, 8'h00});
    send_pkt('{8'hA1, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
               8'h04, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00});
    wait_idle("mul");
    alu_delay = 0;
    tx_mode   = 0;

    // Unknown opcode drained, then a normal packet.
    expect_tx('{8'hEE});
    send_pkt('{8'h77, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04});
    wait_idle("unknown");
    expect_tx('{8'h5A});
    send_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A});
    wait_idle("after_unknown");

    // Length not a multiple of the operand size.
    expect_tx('{8'hEE});
    send_pkt('{8'hA0, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB});
    wait_idle("len_mod");

    // Length shorter than the header.
    expect_tx('{8'hEE});
    send_pkt('{8'hA0, 8'h00, 8'h02, 8'h00});
    wait_idle("len_short");

    // Single-operand DIV returns the operand without an ALU request.
    expect_tx('{8'h78, 8'h56, 8'h34, 8'h12});
    send_pkt('{8'hA2, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12});
    wait_idle("single");

    // Reset mid-operand.
    send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00});
    pulse_reset();
    @(negedge clk);
    chk("rst_opnd_tx_valid", 32'(bus.tx_valid_o), 32'd0);
    chk("rst_opnd_alu_valid", 32'(bus.alu_valid_o), 32'd0);
    chk("rst_opnd_rx_ready", 32'(bus.rx_ready_o), 32'd1);
    @(posedge clk); #1;

    // Reset during RESP with TX stalled.
    tx_mode = 2;
    exp_alu.push_back('{op: 2'd0, a: 32'd1, b: 32'd2});
    alu_res_q.push_back(32'd3);
    expect_tx('{8'h03, 8'h00, 8'h00, 8'h00});
    send_pkt('{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
               8'h02, 8'h00, 8'h00, 8'h00});
    n = 0;
    while (!bus.tx_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("resp_stalled_valid", 32'(bus.tx_valid_o), 32'd1);
    pulse_reset();
    @(negedge clk);
    chk("rst_resp_tx_valid", 32'(bus.tx_valid_o), 32'd0);
    chk("rst_resp_alu_valid", 32'(bus.alu_valid_o), 32'd0);
    @(posedge clk); #1;
    tx_mode = 0;

    // ECHO after reset.
    expect_tx('{8'h11, 8'h22});
    send_pkt('{8'hEC, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22});
    wait_idle("echo_after_rst");

    chk("alu_results_consumed", 32'(alu_res_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
